// File: rtl/uc_scoreboard.sv
// rtl/uc_scoreboard.sv - register write scoreboard with flush/drain handshake
// Optional same-cycle writeback bypass: define UCSB_WB_BYPASS_EN.
module uc_scoreboard #(
    parameter int AW    = 6,
    parameter int NREGS = 64,
    parameter int CNTW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          issue_write,
    input  logic [AW-1:0] issue_dest,
    input  logic [AW-1:0] issue_srcA,
    input  logic [AW-1:0] issue_srcB,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_dest,
    input  logic          flush_req,
    output logic          issue_accept,
    output logic          stall,
    output logic          flush_done,
    output logic [AW:0]   busy_count,
    output logic          wb_error
);

    typedef enum logic [1:0] {RUN, FLUSH_WAIT, FLUSH_DONE} state_t;

    localparam logic [CNTW-1:0] PMAX     = '1;
    localparam logic [CNTW-1:0] PONE     = CNTW'(1);
    localparam logic [AW:0]     BUSY_ONE = (AW+1)'(1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] pend_q [NREGS];
    logic [CNTW-1:0] pend_d [NREGS];
    logic [AW:0]     busy_count_q, busy_count_d;
    logic            wb_error_q, wb_error_d;

    logic rel_a, rel_b, rel_d;
    logic hazard, inc_hit, wb_hit, same_reg;

    // A source is released early only when this cycle's writeback retires its last pending write.
`ifdef UCSB_WB_BYPASS_EN
    assign rel_a = wb_valid && (wb_dest == issue_srcA) && (pend_q[issue_srcA] == PONE);
    assign rel_b = wb_valid && (wb_dest == issue_srcB) && (pend_q[issue_srcB] == PONE);
    assign rel_d = wb_valid && (wb_dest == issue_dest) && (pend_q[issue_dest] == PONE);
`else
    assign rel_a = 1'b0;
    assign rel_b = 1'b0;
    assign rel_d = 1'b0;
`endif

    always_comb begin
        hazard = 1'b0;
        if (pend_q[issue_srcA] != '0 && !rel_a) hazard = 1'b1;
        if (pend_q[issue_srcB] != '0 && !rel_b) hazard = 1'b1;
        if (issue_write && pend_q[issue_dest] == PMAX && !rel_d) hazard = 1'b1;
    end

    assign stall        = issue_valid && (hazard || state_q != RUN);
    assign issue_accept = issue_valid && !stall;

    assign inc_hit  = issue_accept && issue_write && (issue_dest != '0);
    assign wb_hit   = wb_valid && (wb_dest != '0);
    assign same_reg = inc_hit && wb_hit && (issue_dest == wb_dest);

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            pend_d[i] = pend_q[i];
        end
        wb_error_d = wb_error_q;
        // An accept and a writeback to the same register cancel out, even from zero.
        if (inc_hit && !same_reg) begin
            pend_d[issue_dest] = pend_q[issue_dest] + PONE;
        end
        if (wb_hit && !same_reg) begin
            if (pend_q[wb_dest] != '0) begin
                pend_d[wb_dest] = pend_q[wb_dest] - PONE;
            end else begin
                wb_error_d = 1'b1;
            end
        end
        busy_count_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (pend_d[i] != '0) busy_count_d = busy_count_d + BUSY_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:        if (flush_req) state_d = FLUSH_WAIT;
            FLUSH_WAIT: if (busy_count_d == '0) state_d = FLUSH_DONE;
            FLUSH_DONE: state_d = RUN;
            default:    state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            busy_count_q <= '0;
            wb_error_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            busy_count_q <= busy_count_d;
            wb_error_q   <= wb_error_d;
            for (int i = 0; i < NREGS; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign flush_done = (state_q == FLUSH_DONE);
    assign busy_count = busy_count_q;
    assign wb_error   = wb_error_q;

endmodule

// File: tb/tb_uc_scoreboard.sv
// tb/tb_uc_scoreboard.sv - directed and randomized checks of uc_scoreboard against a table model
module tb_uc_scoreboard;

`ifdef UCSB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_write, wb_valid, flush_req;
    logic [5:0] issue_dest, issue_srcA, issue_srcB, wb_dest;
    logic       issue_accept, stall, flush_done, wb_error;
    logic [6:0] busy_count;

    int checks = 0;
    int errors = 0;

    int pend [64];
    int mstate;
    bit merr;
    logic last_stall, last_acc;

    uc_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_write(issue_write),
        .issue_dest(issue_dest), .issue_srcA(issue_srcA), .issue_srcB(issue_srcB),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .flush_req(flush_req),
        .issue_accept(issue_accept), .stall(stall), .flush_done(flush_done),
        .busy_count(busy_count), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mbusy();
        int n = 0;
        for (int i = 0; i < 64; i++) if (pend[i] != 0) n++;
        return n;
    endfunction

    function automatic bit released(int r, bit wv, int wd);
        return BYP && wv && wd == r && pend[r] == 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) pend[i] = 0;
        mstate = 0;
        merr = 1'b0;
    endfunction

    task automatic step(input bit iv, input bit iw, input int d, input int a, input int b,
                        input bit wv, input int wd, input bit fr);
        bit haz, e_stall, e_acc;
        @(negedge clk);
        issue_valid = iv; issue_write = iw;
        issue_dest = 6'(d); issue_srcA = 6'(a); issue_srcB = 6'(b);
        wb_valid = wv; wb_dest = 6'(wd); flush_req = fr;
        #1;
        haz = (a != 0 && pend[a] != 0 && !released(a, wv, wd)) ||
              (b != 0 && pend[b] != 0 && !released(b, wv, wd)) ||
              (iw && d != 0 && pend[d] == 3 && !released(d, wv, wd));
        e_stall = iv && (haz || mstate != 0);
        e_acc   = iv && !e_stall;
        chk("stall", stall, e_stall);
        chk("issue_accept", issue_accept, e_acc);
        last_stall = stall;
        last_acc   = issue_accept;
        @(posedge clk);
        if (e_acc && iw && d != 0 && wv && wd == d) begin
            // accepted write and its writeback in one cycle leave the count alone
        end else begin
            if (e_acc && iw && d != 0) pend[d]++;
            if (wv && wd != 0) begin
                if (pend[wd] > 0) pend[wd]--;
                else merr = 1'b1;
            end
        end
        case (mstate)
            0: if (fr) mstate = 1;
            1: if (mbusy() == 0) mstate = 2;
            default: mstate = 0;
        endcase
        #1;
        chk("busy_count", busy_count, mbusy());
        chk("flush_done", flush_done, mstate == 2);
        chk("wb_error", wb_error, merr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        issue_valid = 0; issue_write = 0; wb_valid = 0; flush_req = 0;
        rst = 1'b1;
        #2;
        model_reset();
        chk("rst_busy", busy_count, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_wb_error", wb_error, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 0; issue_write = 0; issue_dest = 0; issue_srcA = 0; issue_srcB = 0;
        wb_valid = 0; wb_dest = 0; flush_req = 0;
        model_reset();
        #12;
        chk("reset_busy", busy_count, 0);
        chk("reset_flush_done", flush_done, 0);
        chk("reset_wb_error", wb_error, 0);
        chk("reset_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;

        // RAW on reg 5
        step(1, 1, 5, 1, 2, 0, 0, 0);  chk("raw_first_acc", last_acc, 1);
        step(1, 0, 0, 5, 0, 0, 0, 0);  chk("raw_stall", last_stall, 1);
        chk("raw_busy", busy_count, 1);
        step(0, 0, 0, 0, 0, 1, 5, 0);  chk("raw_wb_busy", busy_count, 0);
        step(1, 0, 0, 5, 0, 0, 0, 0);  chk("raw_after_wb_acc", last_acc, 1);

        // same-cycle writeback on a source
        step(1, 1, 5, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 1, 5, 0);
        if (BYP) chk("bypass_acc", last_acc, 1);
        else     chk("no_bypass_stall", last_stall, 1);

        // WAW saturation on reg 7
        for (int i = 0; i < 3; i++) step(1, 1, 7, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0, 0);  chk("waw_sat_stall", last_stall, 1);
        step(0, 0, 0, 0, 0, 1, 7, 0);
        step(1, 1, 7, 0, 0, 0, 0, 0);  chk("waw_after_wb_acc", last_acc, 1);

        // spurious writeback and register 0
        do_reset();
        step(0, 0, 0, 0, 0, 1, 9, 0);  chk("wb_err_set", wb_error, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("wb_err_sticky", wb_error, 1);
        step(1, 1, 0, 0, 0, 1, 0, 0);  chk("reg0_acc", last_acc, 1);
        chk("reg0_busy", busy_count, 0);

        // flush with pending writes on regs 3 and 4
        do_reset();
        step(1, 1, 3, 0, 0, 0, 0, 0);
        step(1, 1, 4, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 2, 0, 0, 1);
        step(1, 0, 0, 1, 2, 0, 0, 1);  chk("flush_block", last_stall, 1);
        step(0, 0, 0, 0, 0, 1, 3, 1);  chk("flush_wait_nodone", flush_done, 0);
        step(0, 0, 0, 0, 0, 1, 4, 1);  chk("flush_pulse", flush_done, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);  chk("flush_done_stall", last_stall, 1);
        chk("flush_pulse_end", flush_done, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);  chk("run_again_acc", last_acc, 1);

        // accept and writeback to reg 6 in one cycle
        do_reset();
        step(1, 1, 6, 0, 0, 0, 0, 0);
        step(1, 1, 6, 0, 0, 1, 6, 0);  chk("same_cycle_busy", busy_count, 1);
        chk("same_cycle_err", wb_error, 0);
        step(0, 0, 0, 0, 0, 1, 6, 0);  chk("same_cycle_drain", busy_count, 0);

        // flush when already empty
        step(0, 0, 0, 0, 0, 0, 0, 1);  chk("empty_flush_c1", flush_done, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("empty_flush_c2", flush_done, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // reset in the middle of a flush
        step(1, 1, 3, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("midflush_rst_nopulse", flush_done, 0);

        // randomized traffic on a small register window
        for (int n = 0; n < 1500; n++) begin
            int d, a, b, wd;
            bit wv;
            d  = $urandom_range(0, 7);
            a  = $urandom_range(0, 7);
            b  = $urandom_range(0, 7);
            wv = ($urandom % 2) == 0;
            wd = ($urandom % 8 != 0) ? $urandom_range(1, 7) : $urandom_range(0, 15);
            step(1'($urandom % 4 != 0), 1'($urandom % 3 != 0), d, a, b, wv, wd,
                 1'($urandom % 24 == 0));
            if (n == 700) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
